// File: rtl/fft_spectrum_buf.sv
// fft_spectrum_buf
//   Captures the bin stream from fft_top and scales every bin to an 8-bit
//   display magnitude. Bins 0..KEEP-1 go into a ping-pong buffer, and the
//   peak bin of each frame is tracked while the frame arrives. A completed
//   frame is published to a readout client by swapping banks. The swap waits
//   while disp_lock is high, so the client never sees a torn frame.
// Ports
//   clk_50m, rst                       clock, async active-high reset
//   data_sop/eop/valid, data_modulus   bin stream from fft_top
//   disp_lock                          client is scanning; defer the bank swap
//   rd_addr -> rd_data                 display bank read, 1-cycle latency
//   frame_valid                        a frame has been published since reset
//   frame_done / frame_err             publish / malformed-frame pulses
//   peak_bin, peak_val                 peak of the published frame
//   drop_cnt                           frames lost while a publish was pending
//
// state | meaning
// IDLE  | waiting for sop
// CAPT  | storing bins, tracking running max
// PEND  | frame complete, waiting for disp_lock low to swap banks
module fft_spectrum_buf #(
  parameter int FFT_POINT = 256,
  parameter int KEEP      = 128,
  parameter int SHIFT     = 8,
  parameter int SKIP_DC   = 1
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        data_sop,
  input  logic        data_eop,
  input  logic        data_valid,
  input  logic [31:0] data_modulus,
  input  logic        disp_lock,
  input  logic [6:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        frame_valid,
  output logic        frame_done,
  output logic        frame_err,
  output logic [6:0]  peak_bin,
  output logic [31:0] peak_val,
  output logic [7:0]  drop_cnt
);

  localparam int IW = $clog2(FFT_POINT);
  localparam int AW = $clog2(KEEP);
  localparam logic [IW-1:0] LAST_IDX = IW'(FFT_POINT - 1);
  localparam logic [IW:0]   KEEP_W   = (IW+1)'(KEEP);

  typedef enum logic [1:0] {IDLE, CAPT, PEND} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           wr_bank_q, wr_bank_d;
  logic [31:0]    max_val_q, max_val_d;
  logic [AW-1:0]  max_bin_q, max_bin_d;
  logic [6:0]     peak_bin_q, peak_bin_d;
  logic [31:0]    peak_val_q, peak_val_d;
  logic           frame_valid_q, frame_valid_d;
  logic           frame_done_q, frame_done_d;
  logic           frame_err_q, frame_err_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;
  logic [7:0]     rd_data_q, rd_data_d;

  logic [7:0]     mem [2][KEEP];

  logic [31:0]    scaled;
  logic [7:0]     mag;
  logic           take_bin, start, in_keep, we;
  logic [IW-1:0]  cur_bin;
  logic [31:0]    base_val;
  logic [AW-1:0]  base_bin;
  logic           rd_bank;

  assign scaled  = data_modulus >> SHIFT;
  assign mag     = (scaled > 32'd255) ? 8'hFF : scaled[7:0];
  assign rd_bank = ~wr_bank_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wr_bank_d     = wr_bank_q;
    peak_bin_d    = peak_bin_q;
    peak_val_d    = peak_val_q;
    frame_valid_d = frame_valid_q;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    drop_cnt_d    = drop_cnt_q;
    take_bin      = 1'b0;
    start         = 1'b0;
    cur_bin       = idx_q;

    case (state_q)
      IDLE: begin
        if (data_valid && data_sop) begin
          take_bin = 1'b1;
          start    = 1'b1;
          cur_bin  = '0;
          idx_d    = IW'(1);
          state_d  = CAPT;
        end
      end
      CAPT: begin
        if (data_valid) begin
          if (data_sop) begin
            // a new sop mid-frame restarts capture with this beat as bin 0
            frame_err_d = 1'b1;
            take_bin    = 1'b1;
            start       = 1'b1;
            cur_bin     = '0;
            idx_d       = IW'(1);
          end else if (data_eop) begin
            take_bin = 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = PEND;
            end else begin
              frame_err_d = 1'b1;
              state_d     = IDLE;
            end
          end else if (idx_q == LAST_IDX) begin
            // last bin of the frame arrived without eop
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else begin
            take_bin = 1'b1;
            idx_d    = idx_q + 1'b1;
          end
        end
      end
      PEND: begin
        if (data_valid && data_sop && (drop_cnt_q != 8'hFF)) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
        if (!disp_lock) begin
          wr_bank_d     = ~wr_bank_q;
          peak_bin_d    = 7'(max_bin_q);
          peak_val_d    = max_val_q;
          frame_valid_d = 1'b1;
          frame_done_d  = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_keep  = ({1'b0, cur_bin} < KEEP_W);
    we       = take_bin && in_keep;
    base_val = start ? 32'd0 : max_val_q;
    base_bin = start ? '0 : max_bin_q;
    max_val_d = base_val;
    max_bin_d = base_bin;
    // strictly greater: ties keep the lower bin
    if (we && ((cur_bin != '0) || (SKIP_DC == 0)) && (data_modulus > base_val)) begin
      max_val_d = data_modulus;
      max_bin_d = cur_bin[AW-1:0];
    end

    rd_data_d = frame_valid_q ? mem[rd_bank][rd_addr] : 8'h00;
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      wr_bank_q     <= 1'b0;
      max_val_q     <= '0;
      max_bin_q     <= '0;
      peak_bin_q    <= '0;
      peak_val_q    <= '0;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      drop_cnt_q    <= '0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wr_bank_q     <= wr_bank_d;
      max_val_q     <= max_val_d;
      max_bin_q     <= max_bin_d;
      peak_bin_q    <= peak_bin_d;
      peak_val_q    <= peak_val_d;
      frame_valid_q <= frame_valid_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // buffer contents need no reset: rd_data is masked until a frame is published
  always_ff @(posedge clk_50m) begin
    if (we) begin
      mem[wr_bank_q][cur_bin[AW-1:0]] <= mag;
    end
  end

  assign rd_data     = rd_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign peak_bin    = peak_bin_q;
  assign peak_val    = peak_val_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
